// File: rtl/config_frame_writer_pkg.sv
// Shared types and constants for the config frame writer.
// Optional build macro: CFG_ADDR_GUARD_EN (address range guard).
package config_frame_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE
  } state_e;

  localparam logic [5:0] CCR0_LO     = 6'h00;
  localparam logic [5:0] CCR0_HI     = 6'h01;
  localparam logic [5:0] CCR1_LO     = 6'h02;
  localparam logic [5:0] CCR1_HI     = 6'h03;
  localparam logic [5:0] CCR2_LO     = 6'h04;
  localparam logic [5:0] CCR2_HI     = 6'h05;
  localparam logic [5:0] CCR3_LO     = 6'h06;
  localparam logic [5:0] CCR3_HI     = 6'h07;
  localparam logic [5:0] COL_SEL     = 6'h08;
  localparam logic [5:0] ROW_COL_SEL = 6'h09;

  localparam int HDR_BURST_BIT = 7;
  localparam int HDR_RSVD_BIT  = 6;
  localparam int HDR_ADDR_MSB  = 5;
  localparam int HDR_ADDR_LSB  = 0;

  function automatic int unsigned cnt_width(input int unsigned t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/config_frame_writer_timeout.sv
// Inter-byte idle counter; saturates at the limit and flags expiry.
// Optional build macro: CFG_ADDR_GUARD_EN (not used here).
import config_frame_writer_pkg::*;

module frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CW = cnt_width(TIMEOUT_CYCLES)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          active,
  input  logic          accept,
  output logic [CW-1:0] count,
  output logic          clear,
  output logic          expired
);

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  assign clear   = accept | ~active;
  assign expired = (TIMEOUT_CYCLES != 0) && active && (count == LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/config_frame_writer.sv
// Parses header/count/data byte frames into config register writes.
// Optional build macro: CFG_ADDR_GUARD_EN suppresses writes above ADDR_MAX.
import config_frame_writer_pkg::*;

module config_frame_writer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [5:0]  ADDR_MAX = 6'h09
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        write_config_n,
  output logic [5:0]  config_address,
  output logic [15:0] config_data,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_error
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);

  state_e         state_q, state_d;
  logic [5:0]     addr_q;
  logic [7:0]     hi_q;
  logic [7:0]     rem_q;
  logic           err_q, err_set;
  logic           done_set;
  logic           accept, active, abort;
  logic           guard_err;
  logic [CW-1:0]  to_count;
  logic           to_clear, to_expired;

  assign rx_ready = (state_q != ST_WRITE);
  assign accept   = rx_valid & rx_ready;
  assign busy     = (state_q != ST_IDLE);
  assign active   = state_q inside {ST_COUNT, ST_DATA_HI, ST_DATA_LO};
  assign abort    = to_expired & ~to_clear;

`ifdef CFG_ADDR_GUARD_EN
  assign guard_err = (state_q == ST_WRITE) && (config_address > ADDR_MAX);
`else
  assign guard_err = 1'b0;
`endif

  assign write_config_n = ~((state_q == ST_WRITE) & ~guard_err);
  assign frame_error    = err_q | guard_err;

  frame_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CW             (CW)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .active  (active),
    .accept  (accept),
    .count   (to_count),
    .clear   (to_clear),
    .expired (to_expired)
  );

  always_comb begin
    state_d  = state_q;
    err_set  = 1'b0;
    done_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept)
          state_d = rx_data[HDR_BURST_BIT] ? ST_COUNT : ST_DATA_HI;
      end
      ST_COUNT: begin
        if (accept && rx_data == 8'd0) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end else if (accept) begin
          state_d = ST_DATA_HI;
        end else if (abort) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          state_d = ST_DATA_LO;
        end else if (abort) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          state_d = ST_WRITE;
        end else if (abort) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end
      end
      ST_WRITE: begin
        if (rem_q <= 8'd1) begin
          state_d  = ST_IDLE;
          done_set = 1'b1;
        end else begin
          state_d = ST_DATA_HI;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      err_q          <= 1'b0;
      frame_done     <= 1'b0;
      addr_q         <= '0;
      hi_q           <= '0;
      rem_q          <= '0;
      config_address <= '0;
      config_data    <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_set;
      frame_done <= done_set;
      if (state_q == ST_IDLE && accept) begin
        addr_q <= rx_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
        rem_q  <= 8'd1;
      end
      if (state_q == ST_COUNT && accept)
        rem_q <= rx_data;
      if (state_q == ST_DATA_HI && accept)
        hi_q <= rx_data;
      // Outputs only move when a word is about to be written
      if (state_q == ST_DATA_LO && accept) begin
        config_address <= addr_q;
        config_data    <= {hi_q, rx_data};
      end
      if (state_q == ST_WRITE) begin
        rem_q  <= rem_q - 8'd1;
        addr_q <= addr_q + 6'd1;
      end
    end
  end

  count_in_range: assert property (
    @(posedge clock) disable iff (!reset_n)
    to_count <= CW'(TIMEOUT_CYCLES)
  );

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed bench for config_frame_writer with a byte-stream reference model.
// Build with CFG_ADDR_GUARD_EN defined to exercise the address guard.
module tb_config_frame_writer;

  localparam int unsigned TO = 8;
  localparam logic [5:0] AMAX = 6'h09;
`ifdef CFG_ADDR_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        write_config_n;
  logic [5:0]  config_address;
  logic [15:0] config_data;
  logic        busy;
  logic        frame_done;
  logic        frame_error;

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  config_frame_writer #(
    .TIMEOUT_CYCLES (TO),
    .ADDR_MAX       (AMAX)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .write_config_n (write_config_n),
    .config_address (config_address),
    .config_data    (config_data),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_error    (frame_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: interprets the accepted byte stream frame by frame
  int          m_pos;   // 0 header, 1 count, 2 high byte, 3 low byte
  bit          m_wr;
  int          m_left;
  int          m_gap;
  logic [5:0]  m_waddr;
  logic [7:0]  m_hi;
  logic [5:0]  m_addr;
  logic [15:0] m_data;
  bit          m_done, m_err;

  always @(posedge clock or negedge reset_n) begin
    bit acc;
    if (!reset_n) begin
      m_pos = 0; m_wr = 0; m_left = 0; m_gap = 0;
      m_waddr = '0; m_hi = '0; m_addr = '0; m_data = '0;
      m_done = 0; m_err = 0;
    end else begin
      acc = rx_valid && !m_wr;
      m_done = 0;
      m_err = 0;
      if (m_wr) begin
        m_wr = 0;
        m_left--;
        m_waddr = m_waddr + 6'd1;
        m_gap = 0;
        if (m_left == 0) begin
          m_pos = 0;
          m_done = 1;
        end else begin
          m_pos = 2;
        end
      end else if (acc) begin
        m_gap = 0;
        case (m_pos)
          0: begin
            m_waddr = rx_data[5:0];
            m_left = 1;
            m_pos = rx_data[7] ? 1 : 2;
          end
          1: begin
            if (rx_data == 8'd0) begin
              m_err = 1;
              m_pos = 0;
            end else begin
              m_left = int'(rx_data);
              m_pos = 2;
            end
          end
          2: begin
            m_hi = rx_data;
            m_pos = 3;
          end
          default: begin
            m_addr = m_waddr;
            m_data = {m_hi, rx_data};
            m_wr = 1;
            m_pos = 0;
          end
        endcase
      end else if (m_pos != 0) begin
        if (m_gap == int'(TO)) begin
          m_err = 1;
          m_pos = 0;
          m_gap = 0;
        end else begin
          m_gap++;
        end
      end
    end
  end

  function automatic logic [26:0] model_vec();
    bit hit;
    hit = GUARD && m_wr && (m_addr > AMAX);
    return {!m_wr, !(m_wr && !hit), (m_pos != 0) || m_wr,
            m_done, m_err || hit, m_addr, m_data};
  endfunction

  always @(negedge clock) begin
    if (cmp_en)
      check("cycle outputs",
            {5'b0, rx_ready, write_config_n, busy, frame_done,
             frame_error, config_address, config_data},
            {5'b0, model_vec()});
  end

  // Observed events for literal checks
  logic [21:0] log_q[$];
  int done_cnt = 0, err_cnt = 0, acc_cnt = 0, nrdy_cnt = 0;

  always @(negedge clock) begin
    if (reset_n) begin
      if (!write_config_n) log_q.push_back({config_address, config_data});
      if (frame_done) done_cnt++;
      if (frame_error) err_cnt++;
      if (rx_valid && rx_ready) acc_cnt++;
      if (!rx_ready) nrdy_cnt++;
    end
  end

  task automatic check_log(input int idx, input logic [5:0] a,
                           input logic [15:0] d);
    logic [31:0] act;
    act = (idx < log_q.size()) ? {10'b0, log_q[idx]} : 32'hxxxxxxxx;
    check("write log", act, {10'b0, a, d});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clock);
    while (!rx_ready && n < 20) begin
      n++;
      @(negedge clock);
    end
    if (!rx_ready) check("handshake wait", 32'd0, 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int base, d0, e0, a0, r0;
    repeat (3) @(posedge clock);
    #1;
    cmp_en = 1'b1;
    reset_n = 1'b1;
    check("reset rx_ready", rx_ready, 1);
    check("reset strobe", write_config_n, 1);
    check("reset busy", busy, 0);
    check("reset addr/data", {config_address, config_data}, 0);
    check("reset pulses", {frame_done, frame_error}, 0);
    idle(2);

    // Single write
    base = log_q.size(); d0 = done_cnt;
    send_byte(8'h06); send_byte(8'h00); send_byte(8'h05);
    check("single strobe latency", write_config_n, 0);
    check("single addr", config_address, 6'h06);
    check("single data", config_data, 16'h0005);
    rx_valid = 1'b0;
    @(posedge clock); #1;
    check("single done pulse", frame_done, 1);
    check("single busy falls", busy, 0);
    idle(3);
    check("single write count", log_q.size() - base, 1);
    check_log(base, 6'h06, 16'h0005);
    check("single done count", done_cnt - d0, 1);
    check("single hold addr", config_address, 6'h06);

    // Burst with address wrap, valid held high throughout
    base = log_q.size(); d0 = done_cnt; a0 = acc_cnt; r0 = nrdy_cnt;
    send_byte(8'hBF); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h33);
    rx_valid = 1'b0;
    idle(4);
    check("burst write count", log_q.size() - base, 3);
    check_log(base, 6'h3F, 16'h1111);
    check_log(base + 1, 6'h00, 16'h2222);
    check_log(base + 2, 6'h01, 16'h3333);
    check("burst done count", done_cnt - d0, 1);
    check("burst bytes accepted", acc_cnt - a0, 8);
    check("burst not-ready cycles", nrdy_cnt - r0, 3);

    // Zero count aborts without a write
    base = log_q.size(); e0 = err_cnt;
    send_byte(8'h80); send_byte(8'h00);
    idle(3);
    check("zero count error", err_cnt - e0, 1);
    check("zero count no write", log_q.size() - base, 0);
    check("zero count idle", busy, 0);

    // Inter-byte timeout, then a fresh header
    base = log_q.size(); e0 = err_cnt;
    send_byte(8'h02); send_byte(8'h12);
    idle(11);
    check("timeout error", err_cnt - e0, 1);
    check("timeout no write", log_q.size() - base, 0);
    check("timeout idle", busy, 0);
    send_byte(8'h07); send_byte(8'hBE); send_byte(8'hEF);
    idle(3);
    check_log(base, 6'h07, 16'hBEEF);

    // Reset asserted during a write cycle
    send_byte(8'h81); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB);
    rx_valid = 1'b0;
    check("pre-reset strobe", write_config_n, 0);
    #2 reset_n = 1'b0;
    #1;
    check("reset strobe drop", write_config_n, 1);
    check("reset busy drop", busy, 0);
    check("reset clears outputs", {config_address, config_data}, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    check("release rx_ready", rx_ready, 1);
    base = log_q.size();
    send_byte(8'h00); send_byte(8'hAB); send_byte(8'hCD);
    idle(3);
    check("post-reset write count", log_q.size() - base, 1);
    check_log(base, 6'h00, 16'hABCD);

`ifdef CFG_ADDR_GUARD_EN
    base = log_q.size(); d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h88); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h01);
    send_byte(8'h02); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h03);
    idle(4);
    check("guard write count", log_q.size() - base, 2);
    check_log(base, 6'h08, 16'h0101);
    check_log(base + 1, 6'h09, 16'h0202);
    check("guard error", err_cnt - e0, 1);
    check("guard done", done_cnt - d0, 1);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
